// File: rtl/riscv_pkg.sv
// Core-wide architectural constants used by the cache units.
// Only the virtual address width is needed by the dcache slice.
package riscv;
    localparam int VLEN = 64;
endpackage

// File: rtl/wt_cache_pkg.sv
// Shared write-through cache geometry and reuse-predictor types.
// Imported by the dcache reuse predictor and its counter sub-module.
package wt_cache_pkg;
    localparam int DCACHE_CL_IDX_WIDTH = 6;
    localparam int DCACHE_NUM_WORDS    = 2 ** DCACHE_CL_IDX_WIDTH;
    localparam int DCACHE_SET_ASSOC    = 4;
    localparam int DCACHE_WAY_WIDTH    = $clog2(DCACHE_SET_ASSOC);

    localparam int REUSE_SIG_WIDTH = 6;

    // Per-line predictor metadata: PC signature of the filling access
    // and whether the line has been hit since it was filled.
    typedef struct packed {
        logic [REUSE_SIG_WIDTH-1:0] sig;
        logic                       reused;
    } reuse_meta_t;
endpackage

// File: rtl/wt_dcache_sat_ctr.sv
// 2-bit saturating counter for one reuse-predictor table entry.
// Ports: clk/rst (async high), flush (sync to INIT), inc/dec (both = hold),
// cnt (current value).
module wt_dcache_sat_ctr #(
    parameter logic [1:0] INIT = 2'b10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       inc,
    input  logic       dec,
    output logic [1:0] cnt
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= INIT;
        end else if (flush) begin
            cnt <= INIT;
        end else if (inc && !dec && cnt != 2'b11) begin
            cnt <= cnt + 2'b01;
        end else if (dec && !inc && cnt != 2'b00) begin
            cnt <= cnt - 2'b01;
        end
    end
endmodule

// File: rtl/wt_dcache_reuse_pred.sv
// Dcache reuse predictor: PC-signature table of saturating counters giving
// the insertion hint for miss fills, trained by first hits and dead evictions.
// Ports: clk_i/rst_i, flush_i; pred_req_i/pred_pc_i -> pred_valid_o/
// pred_result_o (1 cycle); fill_*, hit_*, evict_* line events for training.
module wt_dcache_reuse_pred
    import wt_cache_pkg::*;
#(
    parameter int         SIG_WIDTH = REUSE_SIG_WIDTH,
    parameter logic [1:0] CNT_INIT  = 2'b10
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic                           pred_req_i,
    input  logic [riscv::VLEN-1:0]         pred_pc_i,
    output logic                           pred_valid_o,
    output logic [1:0]                     pred_result_o,
    input  logic                           fill_i,
    input  logic [DCACHE_CL_IDX_WIDTH-1:0] fill_idx_i,
    input  logic [DCACHE_WAY_WIDTH-1:0]    fill_way_i,
    input  logic [riscv::VLEN-1:0]         fill_pc_i,
    input  logic                           hit_i,
    input  logic [DCACHE_CL_IDX_WIDTH-1:0] hit_idx_i,
    input  logic [DCACHE_WAY_WIDTH-1:0]    hit_way_i,
    input  logic                           evict_i,
    input  logic [DCACHE_CL_IDX_WIDTH-1:0] evict_idx_i,
    input  logic [DCACHE_WAY_WIDTH-1:0]    evict_way_i
);
    localparam int CNT_NUM = 2 ** SIG_WIDTH;
    localparam int VLEN    = riscv::VLEN;

    function automatic logic [SIG_WIDTH-1:0] sig_of(
        input logic [VLEN-1:0] pc
    );
        return pc[SIG_WIDTH+1:2] ^ pc[2*SIG_WIDTH+1:SIG_WIDTH+2];
    endfunction

    // Only the folded PC bits feed the signature.
    logic unused_pc;
    assign unused_pc = ^{pred_pc_i[VLEN-1:2*SIG_WIDTH+2], pred_pc_i[1:0],
                         fill_pc_i[VLEN-1:2*SIG_WIDTH+2], fill_pc_i[1:0]};

    reuse_meta_t meta_q [DCACHE_NUM_WORDS][DCACHE_SET_ASSOC];
    logic [1:0]  cnt [CNT_NUM];

    reuse_meta_t          hit_meta;
    reuse_meta_t          evict_meta;
    logic [SIG_WIDTH-1:0] hit_sig;
    logic [SIG_WIDTH-1:0] evict_sig;
    logic                 fill_on_hit;
    logic                 hit_train;
    logic                 evict_train;
    logic [CNT_NUM-1:0]   inc_vec;
    logic [CNT_NUM-1:0]   dec_vec;

    always_comb begin
        hit_meta    = meta_q[hit_idx_i][hit_way_i];
        evict_meta  = meta_q[evict_idx_i][evict_way_i];
        hit_sig     = SIG_WIDTH'(hit_meta.sig);
        evict_sig   = SIG_WIDTH'(evict_meta.sig);
        // A fill to the hit line replaces it, so that hit is not reuse.
        fill_on_hit = fill_i && fill_idx_i == hit_idx_i
                      && fill_way_i == hit_way_i;
        hit_train   = hit_i && !hit_meta.reused && !fill_on_hit && !flush_i;
        evict_train = evict_i && !evict_meta.reused && !flush_i;
        inc_vec     = '0;
        dec_vec     = '0;
        for (int k = 0; k < CNT_NUM; k++) begin
            inc_vec[k] = hit_train && hit_sig == SIG_WIDTH'(k);
            dec_vec[k] = evict_train && evict_sig == SIG_WIDTH'(k);
        end
    end

    for (genvar k = 0; k < CNT_NUM; k++) begin : g_ctr
        wt_dcache_sat_ctr #(
            .INIT (CNT_INIT)
        ) u_ctr (
            .clk   (clk_i),
            .rst   (rst_i),
            .flush (flush_i),
            .inc   (inc_vec[k]),
            .dec   (dec_vec[k]),
            .cnt   (cnt[k])
        );
    end

    // Fill is written after the hit update so it wins on the same line;
    // eviction leaves metadata to the fill that accompanies it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DCACHE_NUM_WORDS; i++)
                for (int j = 0; j < DCACHE_SET_ASSOC; j++)
                    meta_q[i][j] <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < DCACHE_NUM_WORDS; i++)
                for (int j = 0; j < DCACHE_SET_ASSOC; j++)
                    meta_q[i][j] <= '0;
        end else begin
            if (hit_train)
                meta_q[hit_idx_i][hit_way_i].reused <= 1'b1;
            if (fill_i) begin
                meta_q[fill_idx_i][fill_way_i].sig <=
                    REUSE_SIG_WIDTH'(sig_of(fill_pc_i));
                meta_q[fill_idx_i][fill_way_i].reused <= 1'b0;
            end
        end
    end

    // Counters are read before this cycle's training lands: no bypass.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pred_valid_o  <= 1'b0;
            pred_result_o <= 2'b00;
        end else begin
            pred_valid_o <= pred_req_i && !flush_i;
            if (pred_req_i && !flush_i)
                pred_result_o <= cnt[sig_of(pred_pc_i)];
        end
    end
endmodule

// File: tb/tb_wt_dcache_reuse_pred.sv
// Self-checking bench for wt_dcache_reuse_pred: directed scenarios plus
// randomized traffic against a table-level reference model.
module tb_wt_dcache_reuse_pred;
    import wt_cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        pred_req_i = 1'b0;
    logic [63:0] pred_pc_i = '0;
    logic        pred_valid_o;
    logic [1:0]  pred_result_o;
    logic        fill_i = 1'b0;
    logic [5:0]  fill_idx_i = '0;
    logic [1:0]  fill_way_i = '0;
    logic [63:0] fill_pc_i = '0;
    logic        hit_i = 1'b0;
    logic [5:0]  hit_idx_i = '0;
    logic [1:0]  hit_way_i = '0;
    logic        evict_i = 1'b0;
    logic [5:0]  evict_idx_i = '0;
    logic [1:0]  evict_way_i = '0;

    always #5 clk = ~clk;

    wt_dcache_reuse_pred dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .pred_req_i    (pred_req_i),
        .pred_pc_i     (pred_pc_i),
        .pred_valid_o  (pred_valid_o),
        .pred_result_o (pred_result_o),
        .fill_i        (fill_i),
        .fill_idx_i    (fill_idx_i),
        .fill_way_i    (fill_way_i),
        .fill_pc_i     (fill_pc_i),
        .hit_i         (hit_i),
        .hit_idx_i     (hit_idx_i),
        .hit_way_i     (hit_way_i),
        .evict_i       (evict_i),
        .evict_idx_i   (evict_idx_i),
        .evict_way_i   (evict_way_i)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: counter table and per-line metadata.
    int   cnt_m [64];
    int   sig_m [64][4];
    bit   reused_m [64][4];
    logic exp_valid;
    logic [1:0] exp_result;

    function automatic int sig_f(logic [63:0] pc);
        return int'(((pc >> 2) ^ (pc >> 8)) & 64'd63);
    endfunction

    function automatic void model_reset();
        foreach (cnt_m[i]) cnt_m[i] = 2;
        foreach (sig_m[i, j]) begin
            sig_m[i][j] = 0;
            reused_m[i][j] = 0;
        end
        exp_valid = 0;
        exp_result = 2'b00;
    endfunction

    function automatic void model_step();
        int  delta [64];
        bit  ht, et;
        if (flush_i) begin
            model_reset_keep_result();
            return;
        end
        exp_valid = pred_req_i;
        if (pred_req_i) exp_result = 2'(cnt_m[sig_f(pred_pc_i)]);
        foreach (delta[i]) delta[i] = 0;
        ht = hit_i && !reused_m[hit_idx_i][hit_way_i]
             && !(fill_i && fill_idx_i == hit_idx_i && fill_way_i == hit_way_i);
        et = evict_i && !reused_m[evict_idx_i][evict_way_i];
        if (ht) delta[sig_m[hit_idx_i][hit_way_i]] += 1;
        if (et) delta[sig_m[evict_idx_i][evict_way_i]] -= 1;
        foreach (cnt_m[i]) begin
            cnt_m[i] += delta[i];
            if (cnt_m[i] > 3) cnt_m[i] = 3;
            if (cnt_m[i] < 0) cnt_m[i] = 0;
        end
        if (ht) reused_m[hit_idx_i][hit_way_i] = 1;
        if (fill_i) begin
            sig_m[fill_idx_i][fill_way_i] = sig_f(fill_pc_i);
            reused_m[fill_idx_i][fill_way_i] = 0;
        end
    endfunction

    function automatic void model_reset_keep_result();
        logic [1:0] held;
        held = exp_result;
        model_reset();
        exp_result = held;
    endfunction

    // Advance one clock with the currently driven inputs, then clear strobes.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        flush_i = 0;
        pred_req_i = 0;
        fill_i = 0;
        hit_i = 0;
        evict_i = 0;
    endtask

    task automatic do_fill(int idx, int way, logic [63:0] pc);
        fill_i = 1; fill_idx_i = 6'(idx); fill_way_i = 2'(way); fill_pc_i = pc;
    endtask
    task automatic do_hit(int idx, int way);
        hit_i = 1; hit_idx_i = 6'(idx); hit_way_i = 2'(way);
    endtask
    task automatic do_evict(int idx, int way);
        evict_i = 1; evict_idx_i = 6'(idx); evict_way_i = 2'(way);
    endtask

    // Request a prediction and sample it one cycle later.
    task automatic ask(logic [63:0] pc);
        pred_req_i = 1; pred_pc_i = pc;
        tick();
    endtask

    task automatic test_reset();
        rst_i = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pred_valid_o !== 1'b0) begin errors++;
            $display("FAIL reset_valid got=%b exp=0", pred_valid_o); end
        checks++;
        if (pred_result_o !== 2'b00) begin errors++;
            $display("FAIL reset_result got=%b exp=00", pred_result_o); end
        rst_i = 0;
        model_reset();
        ask(64'h1000);
        checks++;
        if (pred_valid_o !== 1'b1) begin errors++;
            $display("FAIL first_valid got=%b exp=1", pred_valid_o); end
        checks++;
        if (pred_result_o !== 2'b10) begin errors++;
            $display("FAIL first_result got=%b exp=10", pred_result_o); end
        tick();
        checks++;
        if (pred_valid_o !== 1'b0 || pred_result_o !== 2'b10) begin errors++;
            $display("FAIL hold got=%b/%b exp=0/10", pred_valid_o, pred_result_o); end
    endtask

    task automatic test_evict_dead();
        do_fill(3, 1, 64'h1000); tick();
        do_evict(3, 1); tick();
        do_evict(3, 1); tick();
        ask(64'h1000);
        checks++;
        if (pred_result_o !== 2'b00) begin errors++;
            $display("FAIL evict_twice got=%b exp=00", pred_result_o); end
        do_evict(3, 1); tick();
        ask(64'h1000);
        checks++;
        if (pred_result_o !== 2'b00) begin errors++;
            $display("FAIL evict_sat got=%b exp=00", pred_result_o); end
    endtask

    task automatic test_hit_reuse();
        do_fill(5, 2, 64'h2040); tick();
        do_hit(5, 2); tick();
        ask(64'h2040);
        checks++;
        if (pred_result_o !== 2'b11) begin errors++;
            $display("FAIL first_hit got=%b exp=11", pred_result_o); end
        do_hit(5, 2); tick();
        do_hit(5, 2); tick();
        do_fill(5, 2, 64'h2040); tick();
        do_hit(5, 2); tick();
        ask(64'h2040);
        checks++;
        if (pred_result_o !== 2'b11) begin errors++;
            $display("FAIL hit_sat got=%b exp=11", pred_result_o); end
        // Reused line is not dead: its eviction must not train.
        do_evict(5, 2); tick();
        ask(64'h2040);
        checks++;
        if (pred_result_o !== 2'b11) begin errors++;
            $display("FAIL reused_evict got=%b exp=11", pred_result_o); end
    endtask

    task automatic test_same_cycle();
        do_fill(7, 0, 64'h0104); tick();
        do_fill(8, 0, 64'h0104); tick();
        do_hit(7, 0); do_evict(8, 0); tick();
        ask(64'h0104);
        checks++;
        if (pred_result_o !== 2'b10) begin errors++;
            $display("FAIL same_sig got=%b exp=10", pred_result_o); end
        do_fill(9, 0, 64'h0008); tick();
        do_fill(10, 0, 64'h000c); tick();
        do_hit(9, 0); do_evict(10, 0); tick();
        ask(64'h0008);
        checks++;
        if (pred_result_o !== 2'b11) begin errors++;
            $display("FAIL diff_sig_inc got=%b exp=11", pred_result_o); end
        ask(64'h000c);
        checks++;
        if (pred_result_o !== 2'b01) begin errors++;
            $display("FAIL diff_sig_dec got=%b exp=01", pred_result_o); end
    endtask

    task automatic test_fill_evict();
        do_fill(11, 3, 64'h0010); tick();
        do_fill(11, 3, 64'h0014); do_evict(11, 3); tick();
        ask(64'h0010);
        checks++;
        if (pred_result_o !== 2'b01) begin errors++;
            $display("FAIL old_sig_dec got=%b exp=01", pred_result_o); end
        ask(64'h0014);
        checks++;
        if (pred_result_o !== 2'b10) begin errors++;
            $display("FAIL new_sig_init got=%b exp=10", pred_result_o); end
        do_hit(11, 3); tick();
        ask(64'h0014);
        checks++;
        if (pred_result_o !== 2'b11) begin errors++;
            $display("FAIL new_sig_inc got=%b exp=11", pred_result_o); end
        ask(64'h0010);
        checks++;
        if (pred_result_o !== 2'b01) begin errors++;
            $display("FAIL old_sig_kept got=%b exp=01", pred_result_o); end
        // Fill and hit on one line: the hit neither trains nor marks reuse.
        do_fill(12, 0, 64'h0018); tick();
        do_fill(12, 0, 64'h0018); do_hit(12, 0); tick();
        ask(64'h0018);
        checks++;
        if (pred_result_o !== 2'b10) begin errors++;
            $display("FAIL fill_hit got=%b exp=10", pred_result_o); end
        do_hit(12, 0); tick();
        ask(64'h0018);
        checks++;
        if (pred_result_o !== 2'b11) begin errors++;
            $display("FAIL after_fill_hit got=%b exp=11", pred_result_o); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) < 60)
                begin pred_req_i = 1; pred_pc_i = 64'($urandom_range(0, 15)) << 2; end
            if ($urandom_range(0, 99) < 40)
                do_fill($urandom_range(0, 3), $urandom_range(0, 3),
                        64'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 99) < 40)
                do_hit($urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 99) < 30)
                do_evict($urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 99) < 2)
                flush_i = 1;
            tick();
            checks++;
            if (pred_valid_o !== exp_valid || pred_result_o !== exp_result) begin
                errors++;
                $display("FAIL random[%0d] got=%b/%b exp=%b/%b", n,
                         pred_valid_o, pred_result_o, exp_valid, exp_result);
            end
        end
    endtask

    task automatic test_flush();
        do_fill(20, 0, 64'h0020); tick();
        do_evict(20, 0); tick();
        do_fill(21, 0, 64'h0024); tick();
        do_hit(21, 0); tick();
        flush_i = 1; pred_req_i = 1; pred_pc_i = 64'h0020;
        do_hit(20, 0); do_evict(21, 0);
        tick();
        checks++;
        if (pred_valid_o !== 1'b0) begin errors++;
            $display("FAIL flush_valid got=%b exp=0", pred_valid_o); end
        ask(64'h0020);
        checks++;
        if (pred_result_o !== 2'b10 || pred_valid_o !== 1'b1) begin errors++;
            $display("FAIL flush_dec_sig got=%b/%b exp=1/10", pred_valid_o, pred_result_o); end
        ask(64'h0024);
        checks++;
        if (pred_result_o !== 2'b10) begin errors++;
            $display("FAIL flush_inc_sig got=%b exp=10", pred_result_o); end
        // Cleared metadata means line 21/0 now trains signature 0.
        do_hit(21, 0); tick();
        ask(64'h0000);
        checks++;
        if (pred_result_o !== 2'(cnt_m[0])) begin errors++;
            $display("FAIL flush_meta got=%b exp=%0d", pred_result_o, cnt_m[0]); end
    endtask

    task automatic test_reset_mid();
        do_fill(30, 1, 64'h0030); tick();
        do_evict(30, 1); tick();
        pred_req_i = 1; pred_pc_i = 64'h0030;
        model_step();
        @(posedge clk);
        #2;
        rst_i = 1;
        #1;
        checks++;
        if (pred_valid_o !== 1'b0 || pred_result_o !== 2'b00) begin errors++;
            $display("FAIL rst_async got=%b/%b exp=0/00", pred_valid_o, pred_result_o); end
        @(posedge clk);
        #1;
        rst_i = 0;
        pred_req_i = 0;
        model_reset();
        ask(64'h0030);
        checks++;
        if (pred_valid_o !== 1'b1 || pred_result_o !== 2'b10) begin errors++;
            $display("FAIL rst_counter got=%b/%b exp=1/10", pred_valid_o, pred_result_o); end
        ask(64'h2040);
        checks++;
        if (pred_result_o !== 2'b10) begin errors++;
            $display("FAIL rst_counter2 got=%b exp=10", pred_result_o); end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 16; n++) begin
            pred_req_i = 1; pred_pc_i = 64'(n) << 2;
            if (n % 3 == 0) do_fill(n, n % 4, 64'(n + 1) << 2);
            if (n % 4 == 1) do_evict(n - 1, (n - 1) % 4);
            tick();
            checks++;
            if (pred_valid_o !== 1'b1 || pred_result_o !== exp_result) begin
                errors++;
                $display("FAIL b2b[%0d] got=%b/%b exp=1/%b", n,
                         pred_valid_o, pred_result_o, exp_result);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_evict_dead();
        test_hit_reuse();
        test_same_cycle();
        test_fill_evict();
        test_back_to_back();
        test_random();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wt_dcache_reuse_pred.md
# wt_dcache_reuse_pred

Reuse predictor for the write-through L1 data cache: it produces the 2-bit insertion prediction that the 4-way PLRU replacement tracker consumes on every miss fill. The predictor keeps a table of 2-bit saturating counters indexed by a PC signature and stores one signature plus one reused bit per cache line. Training is driven by line hits (reuse) and evictions of never-reused lines (dead). It sits beside the dcache miss unit, which samples the result one cycle after the request.

## Interface
Parameters:
- SIG_WIDTH, 6: signature width; the table has 2**SIG_WIDTH counters.
- CNT_INIT, 2'b10: counter value after reset and after flush.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- flush_i  in  1  synchronous clear of all counters and line metadata
- pred_req_i  in  1  miss needs an insertion prediction
- pred_pc_i  in  riscv::VLEN  PC of the missing load/store
- pred_valid_o  out  1  prediction valid; reset 0
- pred_result_o  out  2  counter value; 2'b00 means insert as LRU, otherwise insert as MRU; reset 2'b00
- fill_i  in  1  new line written
- fill_idx_i  in  DCACHE_CL_IDX_WIDTH  fill set index
- fill_way_i  in  $clog2(DCACHE_SET_ASSOC)  fill way
- fill_pc_i  in  riscv::VLEN  PC that caused the fill
- hit_i  in  1  load/store hit
- hit_idx_i  in  DCACHE_CL_IDX_WIDTH  hit set index
- hit_way_i  in  $clog2(DCACHE_SET_ASSOC)  hit way
- evict_i  in  1  valid line being replaced
- evict_idx_i  in  DCACHE_CL_IDX_WIDTH  evicted set index
- evict_way_i  in  $clog2(DCACHE_SET_ASSOC)  evicted way

## Operation
- Signature: sig(pc) = pc[SIG_WIDTH+1:2] ^ pc[2*SIG_WIDTH+1:SIG_WIDTH+2].
- Per-line metadata, DCACHE_NUM_WORDS x DCACHE_SET_ASSOC entries: sig_q (SIG_WIDTH bits), reused_q (1 bit). Reset and flush value: sig 0, reused 0.
- Predict: on pred_req_i, read cnt[sig(pred_pc_i)] and register it into pred_result_o. pred_valid_o is the registered pred_req_i. pred_result_o holds its value while there is no request.
- Fill: sig_q[idx][way] <= sig(fill_pc_i); reused_q[idx][way] <= 0.
- Hit: if reused_q[idx][way] == 0, set it to 1 and increment cnt[sig_q[idx][way]], saturating at 2'b11. A hit on a line already marked reused does not train.
- Evict: if reused_q[idx][way] == 0, decrement cnt[sig_q[idx][way]], saturating at 2'b00. The evicted line's metadata is left to the accompanying fill.
- Simultaneous events:
  - Hit and evict training the same counter: the counter is unchanged.
  - Training of different counters: both updates apply.
  - Fill and evict on the same idx/way: evict trains using the old sig_q, and the fill writes the new metadata.
  - Fill and hit on the same idx/way: fill wins, and the hit neither trains nor sets reused.
- Flush: in the cycle after flush_i, all counters equal CNT_INIT and all metadata is cleared. All other inputs are ignored during the flush cycle. pred_valid_o is 0 in the cycle after flush_i.

## Timing
- Prediction latency is 1 cycle: request at edge N gives pred_valid_o/pred_result_o after edge N+1.
- A prediction reads counter state from before any training in the same cycle, so there is no bypass.
- Training is visible to predictions requested in the next cycle.
- No backpressure: every request is answered, and back-to-back requests give back-to-back results.
- Asserting rst_i at any time immediately sets pred_valid_o=0 and pred_result_o=0, all counters to CNT_INIT and all metadata to 0.

## Structure
- Shared constants in wt_cache_pkg: DCACHE_CL_IDX_WIDTH, DCACHE_SET_ASSOC, DCACHE_NUM_WORDS.
- Add to wt_cache_pkg: localparam for the default REUSE_SIG_WIDTH, and typedef reuse_meta_t {sig, reused}.
- One sub-module, wt_dcache_sat_ctr: a 2-bit saturating counter with inc/dec inputs (both asserted gives hold), plus init/flush. It is instantiated per table entry.

## Test plan
- Reset, then request with PC 0x1000 → next cycle pred_valid_o=1, pred_result_o=2'b10.
- Fill idx 3 way 1 with PC 0x1000, evict it unreused twice → request for 0x1000 returns 2'b00; a third unreused eviction keeps 2'b00 (saturates).
- Fill idx 5 way 2 with PC 0x2040, then hit 3 times → counter goes 2'b10→2'b11 on the first hit only (reused set); a second fill plus hit stays 2'b11.
- Same cycle: hit trains signature S (unreused line) and evict trains S (unreused line) → S counter unchanged; for different signatures, one counter rises and one falls.
- Fill and evict on the same idx/way in one cycle → old signature decremented, new signature stored with reused=0; a following hit increments the new signature only.
- Train counters away from init, then assert flush_i, and separately rst_i mid-stream while pred_req_i=1 → all predictions return 2'b10, and pred_valid_o drops immediately on rst_i.
